// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed 7-segment scanner with frame-synchronous loading,
//            leading-zero blanking and per-slot anode dead time.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int HEX_MODE   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      lz_blank,
  output logic [0:6]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     an_out,
  output logic                      frame_done
);

  localparam int c_div_w = $clog2(CLK_DIV);
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_div_w-1:0]    c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_an_one   = NUM_DIGITS'(1);

  logic [c_div_w-1:0]      div_q, div_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [0:6]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_shifted;
  logic [3:0]              w_cur_nib;
  logic                    w_upper_zero;

  function automatic logic [0:6] f_seg(input logic [3:0] nib);
    logic [0:6] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    if (HEX_MODE == 0 && nib > 4'd9) seg = 7'b1111110;
    return seg;
  endfunction

  assign w_slot_end   = (div_q == c_div_last);
  assign w_wrap       = w_slot_end && (idx_q == c_idx_last);
  // Digits at and above the current index, shifted down to bit 0.
  assign w_shifted    = act_dig_q >> {idx_q, 2'b00};
  assign w_cur_nib    = w_shifted[3:0];
  assign w_upper_zero = (w_shifted == '0);

  always_comb begin
    div_d      = w_slot_end ? '0 : div_q + c_div_w'(1);
    idx_d      = idx_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (w_slot_end) begin
      idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_w'(1);
    end
    // Transfer uses the pre-edge valid flag, so a load in the wrap cycle waits a frame.
    if (w_wrap && pend_vld_q) begin
      act_dig_d  = pend_dig_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    seg_d = f_seg(w_cur_nib);
    if (lz_blank && (idx_q != '0) && w_upper_zero) seg_d = '1;
    dpo_d = ~act_dp_q[idx_q];
    an_d  = '1;
    if (enable && (div_q != '0)) an_d = ~(c_an_one << idx_q);
    fd_d  = w_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      act_dig_q  <= '0;
      act_dp_q   <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= '1;
      dpo_q      <= 1'b1;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dpo_q      <= dpo_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dpo_q;
  assign an_out     = an_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed frame-by-frame checks of seg7_scan_driver (4 digits,
//            4 clocks per slot) in both hex and dash modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam logic [6:0] c_s0 = 7'b0000001;
  localparam logic [6:0] c_s1 = 7'b1001111;
  localparam logic [6:0] c_s2 = 7'b0010010;
  localparam logic [6:0] c_s3 = 7'b0000110;
  localparam logic [6:0] c_s4 = 7'b1001100;
  localparam logic [6:0] c_s7 = 7'b0001111;
  localparam logic [6:0] c_sa = 7'b0001000;
  localparam logic [6:0] c_sb = 7'b1100000;
  localparam logic [6:0] c_sc = 7'b0110001;
  localparam logic [6:0] c_sd = 7'b1000010;
  localparam logic [6:0] c_bl = 7'b1111111;
  localparam logic [6:0] c_ds = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [0:6]  seg_h, seg_d;
  logic        dp_h, dp_d;
  logic [3:0]  an_h, an_d;
  logic        fd_h, fd_d;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1)) u_dut_hex (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_blank(lz_blank), .seg_out(seg_h), .dp_out(dp_h),
    .an_out(an_h), .frame_done(fd_h)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0)) u_dut_dec (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .lz_blank(lz_blank), .seg_out(seg_d), .dp_out(dp_d),
    .an_out(an_d), .frame_done(fd_d)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_an",   32'(an_h),  32'hF);
    chk("rst_seg",  32'(seg_h), 32'h7F);
    chk("rst_dp",   32'(dp_h),  32'h1);
    chk("rst_fd",   32'(fd_h),  32'h0);
    chk("rst_an_d", 32'(an_d),  32'hF);
    chk("rst_seg_d",32'(seg_d), 32'h7F);
  endtask

  // Must be entered on a frame boundary (16*k edges after reset release).
  // exp_h/exp_d pack expected segment codes as {d3,d2,d1,d0}.
  task automatic run_frame(input logic [27:0] exp_h, input logic [27:0] exp_d,
                           input logic [3:0] exp_dp, input logic en,
                           input int ld1_at, input logic [15:0] ld1_val,
                           input int ld2_at, input logic [15:0] ld2_val,
                           input logic [3:0] ld_dp);
    enable = en;
    for (int i = 0; i < 16; i++) begin
      int         idx;
      logic [3:0] an_exp;
      logic [6:0] sh, sd;
      logic       dpx, fdx;
      step();
      idx    = i / 4;
      an_exp = (!en || (i % 4) == 0) ? 4'b1111 : ~(4'b0001 << idx);
      sh     = exp_h[7*idx +: 7];
      sd     = exp_d[7*idx +: 7];
      dpx    = ~exp_dp[idx];
      fdx    = (i == 15);
      chk("an",       32'(an_h),  32'(an_exp));
      chk("seg",      32'(seg_h), 32'(sh));
      chk("dp",       32'(dp_h),  32'(dpx));
      chk("frame_done", 32'(fd_h), 32'(fdx));
      chk("an_dec",   32'(an_d),  32'(an_exp));
      chk("seg_dec",  32'(seg_d), 32'(sd));
      chk("dp_dec",   32'(dp_d),  32'(dpx));
      chk("fd_dec",   32'(fd_d),  32'(fdx));
      load = 1'b0;
      if (i == ld1_at) begin
        load = 1'b1; digits_in = ld1_val; dp_in = ld_dp;
      end
      if (i == ld2_at) begin
        load = 1'b1; digits_in = ld2_val; dp_in = ld_dp;
      end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; lz_blank = 1'b0;
    repeat (3) step();
    chk_reset_outputs();
    rst = 1'b0;

    // Zeros after reset; 1234 loaded early transfers at the first wrap.
    run_frame({c_s0, c_s0, c_s0, c_s0}, {c_s0, c_s0, c_s0, c_s0}, 4'b0000, 1'b1, 0, 16'h1234, -1, 16'h0, 4'b0000);
    run_frame({c_s1, c_s2, c_s3, c_s4}, {c_s1, c_s2, c_s3, c_s4}, 4'b0000, 1'b1, 5, 16'hABCD, -1, 16'h0, 4'b0000);
    lz_blank = 1'b1;
    run_frame({c_sa, c_sb, c_sc, c_sd}, {c_ds, c_ds, c_ds, c_ds}, 4'b0000, 1'b1, 3, 16'h0070, -1, 16'h0, 4'b0000);
    run_frame({c_bl, c_bl, c_s7, c_s0}, {c_bl, c_bl, c_s7, c_s0}, 4'b0000, 1'b1, 2, 16'h0000, -1, 16'h0, 4'b0000);
    // Two loads in one frame: current frame untouched, last load wins.
    run_frame({c_bl, c_bl, c_bl, c_s0}, {c_bl, c_bl, c_bl, c_s0}, 4'b0000, 1'b1, 4, 16'h1111, 9, 16'h2222, 4'b0000);
    // Load lands on the wrap edge: must wait one more frame.
    run_frame({c_s2, c_s2, c_s2, c_s2}, {c_s2, c_s2, c_s2, c_s2}, 4'b0000, 1'b1, 14, 16'h3333, -1, 16'h0, 4'b0000);
    run_frame({c_s2, c_s2, c_s2, c_s2}, {c_s2, c_s2, c_s2, c_s2}, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0, 4'b0000);
    run_frame({c_s3, c_s3, c_s3, c_s3}, {c_s3, c_s3, c_s3, c_s3}, 4'b0000, 1'b1, 0, 16'h3333, -1, 16'h0, 4'b0100);
    run_frame({c_s3, c_s3, c_s3, c_s3}, {c_s3, c_s3, c_s3, c_s3}, 4'b0100, 1'b0, -1, 16'h0, -1, 16'h0, 4'b0000);
    run_frame({c_s3, c_s3, c_s3, c_s3}, {c_s3, c_s3, c_s3, c_s3}, 4'b0100, 1'b1, -1, 16'h0, -1, 16'h0, 4'b0000);

    // Mid-slot reset with a pending load that must never appear.
    load = 1'b1; digits_in = 16'h9999; dp_in = 4'b1111;
    step();
    load = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk_reset_outputs();
    step();
    chk_reset_outputs();
    rst = 1'b0;
    run_frame({c_bl, c_bl, c_bl, c_s0}, {c_bl, c_bl, c_bl, c_s0}, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0, 4'b0000);
    run_frame({c_bl, c_bl, c_bl, c_s0}, {c_bl, c_bl, c_bl, c_s0}, 4'b0000, 1'b1, -1, 16'h0, -1, 16'h0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
